// File: rtl/serial_add_pkg.sv
// Shared types and constants for the serial adder controller.
package serial_add_pkg;

   localparam int unsigned WIDTH_DEFAULT = 8;

   localparam logic ID_REQ0 = 1'b0;
   localparam logic ID_REQ1 = 1'b1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      RUN     = 3'd2,
      CAPTURE = 3'd3,
      RESP    = 3'd4
   } state_t;

endpackage

// File: rtl/serial_add_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester not granted last wins.
module rr_arb2
   import serial_add_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   input  logic       en,
   output logic [1:0] gnt_c
);

   always_comb begin
      gnt_c = 2'b00;
      if (en) begin
         unique case (req)
            2'b01:   gnt_c = 2'b01;
            2'b10:   gnt_c = 2'b10;
            2'b11:   gnt_c = (last == ID_REQ0) ? 2'b10 : 2'b01;
            default: gnt_c = 2'b00;
         endcase
      end
   end

endmodule

// File: rtl/serial_add_ctrl.sv
// Arbitrates two operand requesters onto one serial adder, sequences
// load/shift/capture and returns the tagged result over a valid/ready channel.
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             clear,

   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   output logic             req0_ready,

   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             req1_ready,

   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   output logic             add_set,
   output logic             add_clear,
   input  logic [WIDTH-1:0] add_result,
   input  logic             add_carry,

   output logic             rsp_valid,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_sum,
   output logic             rsp_carry,
   input  logic             rsp_ready
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic             last_id, last_id_d;
   logic             cur_id, cur_id_d;
   logic [WIDTH-1:0] add_a_d, add_b_d;
   logic             add_run, add_run_d;
   logic             rsp_valid_d;
   logic             rsp_id_d;
   logic [WIDTH-1:0] rsp_sum_d;
   logic             rsp_carry_d;

   logic             arb_en_c;
   logic [1:0]       gnt_c;

   // Requests are only considered while idle and out of reset.
   assign arb_en_c = (state == IDLE) && !clear;

   rr_arb2 u_arb (
      .req   ({req1_valid, req0_valid}),
      .last  (last_id),
      .en    (arb_en_c),
      .gnt_c (gnt_c)
   );

   assign req0_ready = gnt_c[0];
   assign req1_ready = gnt_c[1];

   // The adder only distinguishes load (both low) from run (both high).
   assign add_set   = add_run;
   assign add_clear = add_run;

   always_ff @(posedge clk) begin
      if (clear) begin
         state     <= IDLE;
         cnt       <= '0;
         last_id   <= ID_REQ1;
         cur_id    <= ID_REQ0;
         add_a     <= '0;
         add_b     <= '0;
         add_run   <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_id    <= ID_REQ0;
         rsp_sum   <= '0;
         rsp_carry <= 1'b0;
      end else begin
         state     <= state_d;
         cnt       <= cnt_d;
         last_id   <= last_id_d;
         cur_id    <= cur_id_d;
         add_a     <= add_a_d;
         add_b     <= add_b_d;
         add_run   <= add_run_d;
         rsp_valid <= rsp_valid_d;
         rsp_id    <= rsp_id_d;
         rsp_sum   <= rsp_sum_d;
         rsp_carry <= rsp_carry_d;
      end
   end

   always_comb begin
      state_d     = state;
      cnt_d       = cnt;
      last_id_d   = last_id;
      cur_id_d    = cur_id;
      add_a_d     = add_a;
      add_b_d     = add_b;
      rsp_id_d    = rsp_id;
      rsp_sum_d   = rsp_sum;
      rsp_carry_d = rsp_carry;

      unique case (state)
         IDLE: begin
            if (gnt_c[1]) begin
               add_a_d  = req1_a;
               add_b_d  = req1_b;
               cur_id_d = ID_REQ1;
               state_d  = LOAD;
            end else if (gnt_c[0]) begin
               add_a_d  = req0_a;
               add_b_d  = req0_b;
               cur_id_d = ID_REQ0;
               state_d  = LOAD;
            end
         end
         LOAD: begin
            cnt_d   = '0;
            state_d = RUN;
         end
         RUN: begin
            if (cnt == CNT_LAST) begin
               state_d = CAPTURE;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         CAPTURE: begin
            rsp_sum_d   = add_result;
            rsp_carry_d = add_carry;
            rsp_id_d    = cur_id;
            last_id_d   = cur_id;
            state_d     = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Registered outputs are decoded from the next state so they align with it.
      rsp_valid_d = (state_d == RESP);
      add_run_d   = (state_d != LOAD);
   end

endmodule
